// File: rtl/mouse_evt_pkg.sv
// mouse_evt_pkg
//   Shared definitions for the mouse event APB controller: register offsets,
//   CTRL/STATUS/CLR bit positions, the queued event record and a coordinate
//   clamp helper.
package mouse_evt_pkg;

    // Register byte offsets
    localparam int REG_CTRL   = 'h00;
    localparam int REG_STATUS = 'h04;
    localparam int REG_X      = 'h08;
    localparam int REG_Y      = 'h0C;
    localparam int REG_BTN    = 'h10;
    localparam int REG_POP    = 'h14;
    localparam int REG_CLR    = 'h18;

    // CTRL bits
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_IRQ_BIT = 1;

    // STATUS bits
    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_CNT_LSB   = 8;

    // CLR bits
    localparam int CLR_OVF_BIT   = 0;
    localparam int CLR_FLUSH_BIT = 1;

    // Stored coordinate width; wide enough for any screen up to 64k pixels
    localparam int EVT_CW = 16;

    typedef struct packed {
        logic [EVT_CW-1:0] x;
        logic [EVT_CW-1:0] y;
        logic [2:0]        btn;   // {M,R,L}
    } evt_t;

    // Saturate a coordinate to lim-1
    function automatic logic [EVT_CW-1:0] clamp_coord(input logic [EVT_CW-1:0] v,
                                                      input int unsigned      lim);
        return (32'(v) >= lim) ? EVT_CW'(lim - 1) : v;
    endfunction

endpackage

// File: rtl/mouse_evt_fifo.sv
// mouse_evt_fifo
//   Event FIFO with a combinational head view.
//   Ports: clk_i/rstn_i; push + din; pop; flush; head; count; full; empty.
//   Flush beats push and pop. Push while full only lands when a pop happens
//   in the same cycle. Pop while empty is ignored.
module mouse_evt_fifo
    import mouse_evt_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push,
    input  evt_t          din,
    input  logic          pop,
    input  logic          flush,
    output evt_t          head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & (~full | pop) & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mouse_evt_apb_ctrl.sv
// mouse_evt_apb_ctrl
//   APB slave that queues mouse events (x, y, buttons) and exposes the queue
//   head through X/Y/BTN registers, with STATUS, POP and CLR controls.
//   Ports: clk_i, rstn_i (async, active low); APB slave (paddr, pwdata,
//   pwrite, psel, penable -> prdata, pready, pslverr); event input
//   (evt_valid_i, evt_x_i, evt_y_i, evt_btn_i); irq_o.
//   Build option: MOUSE_EVT_IRQ_EN enables CTRL.irq_en and a registered
//   interrupt; without it irq_o is 0 and CTRL bit1 reads 0.
module mouse_evt_apb_ctrl
    import mouse_evt_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int WIDTH          = 1280,
    parameter int HEIGHT         = 1080,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0]  apb_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]  apb_pwdata_i,
    input  logic                       apb_pwrite_i,
    input  logic                       apb_psel_i,
    input  logic                       apb_penable_i,
    output logic [APB_DATA_WIDTH-1:0]  apb_prdata_o,
    output logic                       apb_pready_o,
    output logic                       apb_pslverr_o,
    input  logic                       evt_valid_i,
    input  logic [$clog2(WIDTH)-1:0]   evt_x_i,
    input  logic [$clog2(HEIGHT)-1:0]  evt_y_i,
    input  logic [2:0]                 evt_btn_i,
    output logic                       irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          en_q, ovf_q, pready_q, pslverr_q;
    logic [APB_DATA_WIDTH-1:0] prdata_q;
    logic          irq_en_rb;
    evt_t          evt_in, head;
    logic [CW-1:0] count;
    logic          full, empty;

    logic access, err, wr_ok;
    logic is_ctrl, is_status, is_x, is_y, is_btn, is_pop, is_clr;
    logic pop_req, flush, clr_ovf, push_req, ovf_set;
    logic [31:0] rd_val, status_w;

    // ---------------- decode ----------------
    assign is_ctrl   = (apb_paddr_i == APB_ADDR_WIDTH'(REG_CTRL));
    assign is_status = (apb_paddr_i == APB_ADDR_WIDTH'(REG_STATUS));
    assign is_x      = (apb_paddr_i == APB_ADDR_WIDTH'(REG_X));
    assign is_y      = (apb_paddr_i == APB_ADDR_WIDTH'(REG_Y));
    assign is_btn    = (apb_paddr_i == APB_ADDR_WIDTH'(REG_BTN));
    assign is_pop    = (apb_paddr_i == APB_ADDR_WIDTH'(REG_POP));
    assign is_clr    = (apb_paddr_i == APB_ADDR_WIDTH'(REG_CLR));

    assign err = apb_pwrite_i ? ~(is_ctrl | is_pop | is_clr)
                              : ~(is_ctrl | is_status | is_x | is_y | is_btn);

    // pready_q masks the completion cycle so each transfer acts exactly once
    assign access  = apb_psel_i & apb_penable_i & ~pready_q;
    assign wr_ok   = access & apb_pwrite_i & ~err;
    assign pop_req = wr_ok & is_pop;
    assign flush   = wr_ok & is_clr & apb_pwdata_i[CLR_FLUSH_BIT];
    assign clr_ovf = wr_ok & is_clr & apb_pwdata_i[CLR_OVF_BIT];

    // ---------------- event path ----------------
    assign evt_in.x   = clamp_coord(EVT_CW'(evt_x_i), WIDTH);
    assign evt_in.y   = clamp_coord(EVT_CW'(evt_y_i), HEIGHT);
    assign evt_in.btn = evt_btn_i;

    assign push_req = evt_valid_i & en_q;
    // Full implies non-empty, so a same-cycle POP always makes room
    assign ovf_set  = push_req & full & ~pop_req & ~flush;

    mouse_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (push_req),
        .din    (evt_in),
        .pop    (pop_req),
        .flush  (flush),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // ---------------- read mux ----------------
    always_comb begin
        status_w                        = '0;
        status_w[ST_CNT_LSB +: CW]      = count;
        status_w[ST_OVF_BIT]            = ovf_q;
        status_w[ST_FULL_BIT]           = full;
        status_w[ST_EMPTY_BIT]          = empty;

        rd_val = '0;
        if (is_ctrl) begin
            rd_val[CTRL_EN_BIT]  = en_q;
            rd_val[CTRL_IRQ_BIT] = irq_en_rb;
        end else if (is_status) begin
            rd_val = status_w;
        end else if (!empty) begin
            if (is_x)   rd_val = 32'(head.x);
            if (is_y)   rd_val = 32'(head.y);
            if (is_btn) rd_val = 32'(head.btn);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= access;
            pslverr_q <= access & err;
            prdata_q  <= (access & ~apb_pwrite_i & ~err) ? APB_DATA_WIDTH'(rd_val) : '0;
            if (wr_ok && is_ctrl) en_q <= apb_pwdata_i[CTRL_EN_BIT];
            // A new overflow outranks a same-cycle clear
            if (ovf_set)      ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

`ifdef MOUSE_EVT_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ok && is_ctrl) irq_en_q <= apb_pwdata_i[CTRL_IRQ_BIT];
            irq_q <= irq_en_q & (~empty | ovf_q);
        end
    end

    assign irq_en_rb = irq_en_q;
    assign irq_o     = irq_q;
`else
    assign irq_en_rb = 1'b0;
    assign irq_o     = 1'b0;
`endif

    // Only a few pwdata bits are meaningful
    logic unused_ok;
    assign unused_ok = &{1'b0, apb_pwdata_i};

    assign apb_prdata_o  = prdata_q;
    assign apb_pready_o  = pready_q;
    assign apb_pslverr_o = pslverr_q;

endmodule

// File: tb/tb_mouse_evt_apb_ctrl.sv
module tb_mouse_evt_apb_ctrl;

    localparam logic [11:0] A_CTRL = 12'h000, A_STAT = 12'h004, A_X = 12'h008,
                            A_Y = 12'h00C, A_BTN = 12'h010, A_POP = 12'h014,
                            A_CLR = 12'h018, A_BAD = 12'h040, A_UNAL = 12'h002;
`ifdef MOUSE_EVT_IRQ_EN
    localparam logic [31:0] CTRL_RB = 32'h3;
    localparam logic        IRQ_EXP = 1'b1;
`else
    localparam logic [31:0] CTRL_RB = 32'h1;
    localparam logic        IRQ_EXP = 1'b0;
`endif

    logic        clk_i = 1'b0, rstn_i = 1'b0;
    logic [11:0] apb_paddr_i = '0;
    logic [31:0] apb_pwdata_i = '0;
    logic        apb_pwrite_i = 1'b0, apb_psel_i = 1'b0, apb_penable_i = 1'b0;
    logic [31:0] apb_prdata_o;
    logic        apb_pready_o, apb_pslverr_o;
    logic        evt_valid_i = 1'b0;
    logic [10:0] evt_x_i = '0, evt_y_i = '0;
    logic [2:0]  evt_btn_i = '0;
    logic        irq_o;

    int n_cmp = 0, n_bad = 0;

    mouse_evt_apb_ctrl dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .apb_paddr_i(apb_paddr_i), .apb_pwdata_i(apb_pwdata_i),
        .apb_pwrite_i(apb_pwrite_i), .apb_psel_i(apb_psel_i),
        .apb_penable_i(apb_penable_i), .apb_prdata_o(apb_prdata_o),
        .apb_pready_o(apb_pready_o), .apb_pslverr_o(apb_pslverr_o),
        .evt_valid_i(evt_valid_i), .evt_x_i(evt_x_i), .evt_y_i(evt_y_i),
        .evt_btn_i(evt_btn_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic send_evt(input int x, input int y, input logic [2:0] b);
        @(negedge clk_i);
        evt_valid_i = 1'b1; evt_x_i = 11'(x); evt_y_i = 11'(y); evt_btn_i = b;
        @(negedge clk_i);
        evt_valid_i = 1'b0;
    endtask

    // One APB transfer; with_evt raises evt_valid_i in the access cycle
    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                       input bit with_evt, input int ex, input int ey,
                       output logic [31:0] rd, output logic err);
        bit got = 0;
        rd = '0; err = 1'b0;
        @(negedge clk_i);
        apb_psel_i = 1'b1; apb_penable_i = 1'b0; apb_pwrite_i = wr;
        apb_paddr_i = a; apb_pwdata_i = wd;
        @(negedge clk_i);
        apb_penable_i = 1'b1;
        if (with_evt) begin
            evt_valid_i = 1'b1; evt_x_i = 11'(ex); evt_y_i = 11'(ey); evt_btn_i = 3'd5;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk_i); #1;
            if (apb_pready_o) begin
                got = 1; rd = apb_prdata_o; err = apb_pslverr_o;
            end
        end
        if (!got) chk("pready_timeout", 32'd0, 32'd1);
        @(negedge clk_i);
        apb_psel_i = 1'b0; apb_penable_i = 1'b0; evt_valid_i = 1'b0;
        @(posedge clk_i); #1;
        if (got) chk("pready_one_cycle", 32'(apb_pready_o), 32'd0);
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d; logic e;
        apb(1'b0, a, '0, 1'b0, 0, 0, d, e);
        chk({nm, "_err"}, 32'(e), 32'd0);
        chk(nm, d, exp);
    endtask

    task automatic wr_do(input string nm, input logic [11:0] a, input logic [31:0] wd,
                         input bit with_evt, input int ex);
        logic [31:0] d; logic e;
        apb(1'b1, a, wd, with_evt, ex, 7, d, e);
        chk({nm, "_err"}, 32'(e), 32'd0);
    endtask

    typedef struct {
        bit          ev;
        int          ex, ey;
        logic [2:0]  eb;
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        string       nm;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit ev, input int ex, input int ey, input logic [2:0] eb,
                       input bit wr, input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input bit ee, input string nm);
        vec_t v;
        v.ev = ev; v.ex = ex; v.ey = ey; v.eb = eb; v.wr = wr; v.addr = a;
        v.wd = wd; v.exp_rd = er; v.exp_err = ee; v.nm = nm;
        vt.push_back(v);
    endtask

    initial begin
        logic [31:0] d; logic e; bit saw_rdy;

        //   ev ex    ey    eb    wr addr    wd     exp_rd   err name
        add(0, 0,    0,    3'd0, 0, A_STAT, 0,     32'h1,   0, "rst_status");
        add(0, 0,    0,    3'd0, 0, A_CTRL, 0,     32'h0,   0, "rst_ctrl");
        add(0, 0,    0,    3'd0, 0, A_X,    0,     32'h0,   0, "empty_x");
        add(1, 5,    5,    3'd1, 0, A_STAT, 0,     32'h1,   0, "disabled_drop");
        add(0, 0,    0,    3'd0, 1, A_CTRL, 32'h3, 32'h0,   0, "wr_ctrl");
        add(0, 0,    0,    3'd0, 0, A_CTRL, 0,     CTRL_RB, 0, "rd_ctrl");
        add(1, 100,  200,  3'd1, 0, A_X,    0,     32'd100, 0, "x_100");
        add(0, 0,    0,    3'd0, 0, A_Y,    0,     32'd200, 0, "y_200");
        add(0, 0,    0,    3'd0, 0, A_BTN,  0,     32'd1,   0, "btn_1");
        add(0, 0,    0,    3'd0, 0, A_STAT, 0,     32'h100, 0, "status_cnt1");
        add(0, 0,    0,    3'd0, 1, A_POP,  0,     32'h0,   0, "pop");
        add(0, 0,    0,    3'd0, 0, A_STAT, 0,     32'h1,   0, "status_popped");
        add(0, 0,    0,    3'd0, 1, A_POP,  0,     32'h0,   0, "pop_empty");
        add(0, 0,    0,    3'd0, 0, A_STAT, 0,     32'h1,   0, "status_pop_empty");
        add(1, 2000, 1500, 3'd7, 0, A_X,    0,     32'd1279,0, "x_clamp");
        add(0, 0,    0,    3'd0, 0, A_Y,    0,     32'd1079,0, "y_clamp");
        add(0, 0,    0,    3'd0, 0, A_BTN,  0,     32'd7,   0, "btn_7");
        add(0, 0,    0,    3'd0, 1, A_POP,  0,     32'h0,   0, "pop2");
        add(1, 1279, 1079, 3'd2, 0, A_X,    0,     32'd1279,0, "x_edge");
        add(0, 0,    0,    3'd0, 0, A_Y,    0,     32'd1079,0, "y_edge");
        add(0, 0,    0,    3'd0, 1, A_POP,  0,     32'h0,   0, "pop3");
        add(1, 1280, 1080, 3'd4, 0, A_X,    0,     32'd1279,0, "x_width");
        add(0, 0,    0,    3'd0, 0, A_Y,    0,     32'd1079,0, "y_height");
        add(0, 0,    0,    3'd0, 1, A_POP,  0,     32'h0,   0, "pop4");
        add(0, 0,    0,    3'd0, 1, A_X,    32'h55,32'h0,   1, "wr_x_err");
        add(0, 0,    0,    3'd0, 0, A_POP,  0,     32'h0,   1, "rd_pop_err");
        add(0, 0,    0,    3'd0, 0, A_CLR,  0,     32'h0,   1, "rd_clr_err");
        add(0, 0,    0,    3'd0, 0, A_BAD,  0,     32'h0,   1, "rd_unmapped");
        add(0, 0,    0,    3'd0, 0, A_UNAL, 0,     32'h0,   1, "rd_unaligned");
        add(0, 0,    0,    3'd0, 1, A_BAD,  32'h0, 32'h0,   1, "wr_unmapped");
        add(0, 0,    0,    3'd0, 1, A_STAT, 32'h0, 32'h0,   1, "wr_status_err");
        add(0, 0,    0,    3'd0, 1, A_Y,    32'h0, 32'h0,   1, "wr_y_err");
        add(0, 0,    0,    3'd0, 1, A_BTN,  32'h0, 32'h0,   1, "wr_btn_err");
        add(0, 0,    0,    3'd0, 0, A_CTRL, 0,     CTRL_RB, 0, "ctrl_kept");
        add(0, 0,    0,    3'd0, 0, A_STAT, 0,     32'h1,   0, "status_kept");

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_pready",  32'(apb_pready_o),  32'd0);
        chk("rst_pslverr", 32'(apb_pslverr_o), 32'd0);
        chk("rst_prdata",  apb_prdata_o,       32'd0);
        chk("rst_irq",     32'(irq_o),         32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        foreach (vt[i]) begin
            if (vt[i].ev) send_evt(vt[i].ex, vt[i].ey, vt[i].eb);
            apb(vt[i].wr, vt[i].addr, vt[i].wd, 1'b0, 0, 0, d, e);
            chk({vt[i].nm, "_err"}, 32'(e), 32'(vt[i].exp_err));
            if (!vt[i].wr) chk(vt[i].nm, d, vt[i].exp_rd);
        end

        // Fill past depth: 8 stored, 9th overflows
        for (int i = 0; i < 9; i++) send_evt(10 + i, 20 + i, 3'(i));
        rd_chk("fill_status", A_STAT, 32'h806);
        rd_chk("fill_head_x", A_X, 32'd10);
        wr_do("clr_ovf", A_CLR, 32'h1, 1'b0, 0);
        rd_chk("clr_ovf_status", A_STAT, 32'h802);

        // Pop and push together while full: both succeed, no overflow
        wr_do("pop_push", A_POP, 32'h0, 1'b1, 99);
        rd_chk("pop_push_status", A_STAT, 32'h802);
        rd_chk("pop_push_head", A_X, 32'd11);

        // Overflow in the same cycle as clear: overflow stays
        wr_do("clr_vs_ovf", A_CLR, 32'h1, 1'b1, 98);
        rd_chk("clr_vs_ovf_status", A_STAT, 32'h806);

        // Flush beats a same-cycle push; overflow untouched by flush
        wr_do("flush_push", A_CLR, 32'h2, 1'b1, 97);
        rd_chk("flush_status", A_STAT, 32'h5);
        wr_do("clr_ovf2", A_CLR, 32'h1, 1'b0, 0);
        rd_chk("clr_ovf2_status", A_STAT, 32'h1);

        // Order after flush
        for (int i = 1; i <= 3; i++) send_evt(i, 0, 3'd0);
        for (int i = 1; i <= 3; i++) begin
            rd_chk($sformatf("order_x%0d", i), A_X, 32'(i));
            wr_do("order_pop", A_POP, 32'h0, 1'b0, 0);
        end
        rd_chk("order_status", A_STAT, 32'h1);

        // Interrupt follows a queued event, clears after pop
        send_evt(50, 60, 3'd1);
        @(posedge clk_i); #1;
        chk("irq_set", 32'(irq_o), 32'(IRQ_EXP));
        wr_do("irq_pop", A_POP, 32'h0, 1'b0, 0);
        chk("irq_clr", 32'(irq_o), 32'd0);

        // Reset during the access phase aborts the transfer
        send_evt(70, 80, 3'd2);
        @(negedge clk_i);
        apb_psel_i = 1'b1; apb_pwrite_i = 1'b0; apb_paddr_i = A_STAT;
        @(negedge clk_i);
        apb_penable_i = 1'b1;
        #2 rstn_i = 1'b0;
        saw_rdy = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (apb_pready_o) saw_rdy = 1;
        end
        chk("abort_no_pready", 32'(saw_rdy), 32'd0);
        @(negedge clk_i);
        apb_psel_i = 1'b0; apb_penable_i = 1'b0; rstn_i = 1'b1;
        rd_chk("abort_status", A_STAT, 32'h1);
        rd_chk("abort_ctrl", A_CTRL, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
